// File: rtl/instr_assembler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_assembler_pkg
//  Description : Shared constants for the instruction assembler. The opcodes
//                are the same ones the main control decoder matches on. The
//                package also holds the request-kind codes and the FSM state
//                encoding.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package instr_assembler_pkg;

    // Primary opcodes, bits [31:26] of the instruction word
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Request kind codes on req_kind; 6 and 7 are illegal
    localparam logic [2:0] c_KIND_LW    = 3'd0;
    localparam logic [2:0] c_KIND_SW    = 3'd1;
    localparam logic [2:0] c_KIND_BEQ   = 3'd2;
    localparam logic [2:0] c_KIND_RTYPE = 3'd3;
    localparam logic [2:0] c_KIND_J     = 3'd4;
    localparam logic [2:0] c_KIND_ADDI  = 3'd5;

    // Loader FSM state encoding
    localparam int         c_ST_W     = 1;
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_WRITE = 1'b1;

endpackage : instr_assembler_pkg
`default_nettype wire

// File: rtl/instr_assembler_encode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encode
//  Description : Purely combinational encoder. Turns a symbolic request
//                (kind + fields) into a 32-bit MIPS word. Fields that the
//                given kind does not use are ignored. An unknown kind yields
//                a zero word and raises o_illegal.
//  Ports       : i_kind[2:0]   request kind
//                i_rs/i_rt/i_rd/i_shamt[4:0], i_funct[5:0] register fields
//                i_imm[15:0]   immediate / branch offset
//                i_target[25:0] jump target
//                o_word[31:0]  encoded instruction
//                o_illegal     kind not recognised
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encode
    import instr_assembler_pkg::*;
(
    input  logic [2:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_kind)
            c_KIND_LW:    o_word = {OP_LW,    i_rs, i_rt, i_imm};
            c_KIND_SW:    o_word = {OP_SW,    i_rs, i_rt, i_imm};
            c_KIND_BEQ:   o_word = {OP_BEQ,   i_rs, i_rt, i_imm};
            c_KIND_RTYPE: o_word = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct};
            c_KIND_J:     o_word = {OP_J,     i_target};
            c_KIND_ADDI:  o_word = {OP_ADDI,  i_rs, i_rt, i_imm};
            default:      o_illegal = 1'b1;
        endcase
    end

endmodule : instr_encode
`default_nettype wire

// File: rtl/instr_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : instr_assembler
//  Description : Program loader placed in front of instruction memory. It
//                accepts symbolic instruction requests over a valid/ready
//                port, encodes each one, and writes the words to consecutive
//                imem addresses over a strobe/ack port. It stops accepting
//                requests after MAX_WORDS words until start or reset.
//  Ports       : clk, reset (async, active-high)
//                start                  restart at BASE_ADDR (IDLE only)
//                req_valid / req_ready  request handshake
//                req_kind, req_rs, req_rt, req_rd, req_shamt, req_funct,
//                req_imm, req_target    request fields
//                mem_we, mem_addr, mem_wdata, mem_ack   imem write port
//                count                  words written since reset/start
//                full                   count == MAX_WORDS
//                err_illegal            sticky illegal-kind flag
//  Revision    : 1.0  initial release
// ============================================================================
module instr_assembler
    import instr_assembler_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal
);

    localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_MAX       = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_COUNT_ONE = (ADDR_W+1)'(1);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_stateNext;

    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [31:0]       r_memWdata;
    logic [ADDR_W:0]   r_count;
    logic              r_errIllegal;

    logic [31:0]       w_encWord;
    logic              w_encIllegal;
    logic              w_full;
    logic              w_ready;
    logic              w_accept;

    instr_encode u_encode (
        .i_kind    (req_kind),
        .i_rs      (req_rs),
        .i_rt      (req_rt),
        .i_rd      (req_rd),
        .i_shamt   (req_shamt),
        .i_funct   (req_funct),
        .i_imm     (req_imm),
        .i_target  (req_target),
        .o_word    (w_encWord),
        .o_illegal (w_encIllegal)
    );

    assign w_full   = (r_count == c_MAX);
    assign w_accept = req_valid & w_ready;

    // Next-state and handshake. Ready is withheld while start is high, so a
    // restart and an accept can never happen in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_ready     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_ready = ~w_full & ~start;
                if (req_valid && w_ready && !w_encIllegal) begin
                    w_stateNext = c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                if (mem_ack) begin
                    w_stateNext = c_ST_IDLE;
                end
            end
            default: w_stateNext = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath registers. The write port is driven straight from flops, so
    // the strobe, address and data stay constant for the whole WRITE state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memWe      <= 1'b0;
            r_memAddr    <= c_BASE;
            r_memWdata   <= '0;
            r_count      <= '0;
            r_errIllegal <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_count      <= '0;
                        r_memAddr    <= c_BASE;
                        r_errIllegal <= 1'b0;
                    end else if (w_accept) begin
                        if (w_encIllegal) begin
                            r_errIllegal <= 1'b1;
                        end else begin
                            r_memWdata <= w_encWord;
                            r_memWe    <= 1'b1;
                        end
                    end
                end
                c_ST_WRITE: begin
                    if (mem_ack) begin
                        r_memWe   <= 1'b0;
                        r_count   <= r_count + c_COUNT_ONE;
                        // Wraps naturally modulo 2**ADDR_W
                        r_memAddr <= r_memAddr + c_ADDR_ONE;
                    end
                end
                default: r_memWe <= 1'b0;
            endcase
        end
    end

    assign req_ready   = w_ready;
    assign mem_we      = r_memWe;
    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;
    assign count       = r_count;
    assign full        = w_full;
    assign err_illegal = r_errIllegal;

endmodule : instr_assembler
`default_nettype wire
